pi_out_limiter: RTL and testbench

//  Output stage directly downstream of the discrete PI controller (PI_water family).

---
 rtl/pi_out_limiter_pkg.sv | 27 ++
 rtl/pi_out_limiter_fp32_order_key.sv | 15 +
 rtl/pi_out_limiter.sv | 121 ++++++++++++
 tb/tb_pi_out_limiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pi_out_limiter_pkg.sv
// Shared fp32 definitions and ordering helpers for the PI output limiter.
package pi_out_limiter_pkg;

  typedef logic [31:0] single_t;

  localparam single_t FP32_POS_ONE = 32'h3f80_0000;
  localparam single_t FP32_NEG_ONE = 32'hbf80_0000;

  typedef enum logic [1:0] {
    CLS_PASS,
    CLS_HI,
    CLS_LO,
    CLS_NAN
  } cls_t;

  // Monotonic unsigned key for non-NaN fp32; both zeros map to the same key.
  function automatic logic [31:0] order_key(input single_t x);
    if (x[30:0] == '0)
      return 32'h8000_0000;
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

  function automatic logic fp32_is_nan(input single_t x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction

endpackage

// File: rtl/pi_out_limiter_fp32_order_key.sv
// Combinational fp32 -> unsigned order key, plus NaN detect.
module fp32_order_key
  import pi_out_limiter_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] key,
  output logic        is_nan
);

  always_comb begin
    key    = order_key(x);
    is_nan = fp32_is_nan(x);
  end

endmodule

// File: rtl/pi_out_limiter.sv
// Two-stage fp32 output limiter behind the PI controller: clamp, status, sticky NaN.
module pi_out_limiter
  import pi_out_limiter_pkg::*;
#(
  parameter logic [31:0] LIM_HI    = FP32_POS_ONE,
  parameter logic [31:0] LIM_LO    = FP32_NEG_ONE,
  parameter int unsigned SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rst_user,
  input  logic                 sta,
  input  logic [31:0]          y_in,
  output logic [31:0]          y_out,
  output logic                 done_sig,
  output logic                 sat_hi,
  output logic                 sat_lo,
  output logic [SAT_CNT_W-1:0] sat_cnt,
  output logic                 nan_err
);

  localparam logic [31:0] KEY_HI = order_key(LIM_HI);
  localparam logic [31:0] KEY_LO = order_key(LIM_LO);

  if (KEY_LO > KEY_HI) begin : g_lim_check
    $error("pi_out_limiter: LIM_LO is greater than LIM_HI");
  end

  logic [31:0]          y_key;
  logic                 y_nan;
  cls_t                 cls_in;
  logic                 v1;
  logic [31:0]          y1;
  cls_t                 cls1;
  logic [SAT_CNT_W-1:0] sat_cnt_next;

  fp32_order_key u_key (
    .x      (y_in),
    .key    (y_key),
    .is_nan (y_nan)
  );

  // gt_hi is tested before lt_lo, so an inverted limit pair still clamps high.
  always_comb begin
    cls_in = CLS_PASS;
    if (y_nan)
      cls_in = CLS_NAN;
    else if (y_key > KEY_HI)
      cls_in = CLS_HI;
    else if (y_key < KEY_LO)
      cls_in = CLS_LO;
  end

  always_comb begin
    sat_cnt_next = sat_cnt;
    if (sat_cnt != '1)
      sat_cnt_next = sat_cnt + SAT_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      y1   <= '0;
      cls1 <= CLS_PASS;
    end else if (rst_user) begin
      v1   <= 1'b0;
      y1   <= '0;
      cls1 <= CLS_PASS;
    end else begin
      v1 <= sta;
      if (sta) begin
        y1   <= y_in;
        cls1 <= cls_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_sig <= 1'b0;
      y_out    <= '0;
      sat_hi   <= 1'b0;
      sat_lo   <= 1'b0;
      sat_cnt  <= '0;
      nan_err  <= 1'b0;
    end else if (rst_user) begin
      done_sig <= 1'b0;
      y_out    <= '0;
      sat_hi   <= 1'b0;
      sat_lo   <= 1'b0;
      sat_cnt  <= '0;
      nan_err  <= 1'b0;
    end else begin
      done_sig <= v1;
      if (v1) begin
        case (cls1)
          CLS_NAN: nan_err <= 1'b1;
          CLS_HI: begin
            y_out   <= LIM_HI;
            sat_hi  <= 1'b1;
            sat_lo  <= 1'b0;
            sat_cnt <= sat_cnt_next;
          end
          CLS_LO: begin
            y_out   <= LIM_LO;
            sat_hi  <= 1'b0;
            sat_lo  <= 1'b1;
            sat_cnt <= sat_cnt_next;
          end
          default: begin
            y_out   <= y1;
            sat_hi  <= 1'b0;
            sat_lo  <= 1'b0;
            sat_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pi_out_limiter.sv
// Self-checking bench for pi_out_limiter against a sign/magnitude clamp model.
module tb_pi_out_limiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_user = 1'b0;
  logic        sta = 1'b0;
  logic [31:0] y_in = '0;

  logic [31:0] y_out, y_out2;
  logic        done_sig, done2, sat_hi, sat_hi2, sat_lo, sat_lo2, nan_err, nan2;
  logic [15:0] sat_cnt;
  logic [1:0]  sat_cnt2;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_y;
  logic        m_hi, m_lo, m_nan;
  int          m_cnt;

  always #5 clk = ~clk;

  pi_out_limiter dut (
    .clk(clk), .rst(rst), .rst_user(rst_user), .sta(sta), .y_in(y_in),
    .y_out(y_out), .done_sig(done_sig), .sat_hi(sat_hi), .sat_lo(sat_lo),
    .sat_cnt(sat_cnt), .nan_err(nan_err)
  );

  pi_out_limiter #(.SAT_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .rst_user(rst_user), .sta(sta), .y_in(y_in),
    .y_out(y_out2), .done_sig(done2), .sat_hi(sat_hi2), .sat_lo(sat_lo2),
    .sat_cnt(sat_cnt2), .nan_err(nan2)
  );

  logic [53:0] obs;
  assign obs = {done_sig, y_out, sat_hi, sat_lo, sat_cnt, nan_err, sat_cnt2};

  function automatic void model_reset();
    m_y = '0; m_hi = 0; m_lo = 0; m_nan = 0; m_cnt = 0;
  endfunction

  // Limits are +/-1.0: a non-NaN value is out of range when its magnitude exceeds 1.0.
  function automatic void model_step(input logic [31:0] y);
    logic nan;
    logic big;
    nan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    big = y[30:0] > 31'h3f80_0000;
    if (nan) m_nan = 1;
    else if (big && !y[31]) begin m_y = 32'h3f80_0000; m_hi = 1; m_lo = 0; m_cnt++; end
    else if (big && y[31])  begin m_y = 32'hbf80_0000; m_hi = 0; m_lo = 1; m_cnt++; end
    else begin m_y = y; m_hi = 0; m_lo = 0; m_cnt = 0; end
  endfunction

  function automatic logic [53:0] exp_vec(input logic d);
    logic [15:0] c16;
    logic [1:0]  c2;
    c16 = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    c2  = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    return {d, m_y, m_hi, m_lo, c16, m_nan, c2};
  endfunction

  task automatic drive_one(input logic [31:0] y);
    sta = 1; y_in = y;
    @(posedge clk); #1;
    sta = 0; y_in = $urandom;
  endtask

  task automatic test_reset();
    #2 rst = 0;
    #1;
    model_reset();
    total++;
    if (obs !== exp_vec(0)) begin bad++; $display("FAIL reset: got %h want %h", obs, exp_vec(0)); end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    total++;
    if (obs !== exp_vec(0)) begin bad++; $display("FAIL reset_hold: got %h want %h", obs, exp_vec(0)); end
  endtask

  task automatic test_pass();
    logic [31:0] v [3] = '{32'h3f00_0000, 32'h3f80_0000, 32'hbf80_0000};
    foreach (v[i]) begin
      drive_one(v[i]);
      total++;
      if (obs !== exp_vec(0)) begin bad++; $display("FAIL pass_lat1: got %h want %h", obs, exp_vec(0)); end
      @(posedge clk); #1;
      model_step(v[i]);
      total++;
      if (obs !== exp_vec(1)) begin bad++; $display("FAIL pass: got %h want %h", obs, exp_vec(1)); end
    end
  endtask

  task automatic test_sat_hi();
    logic [31:0] v [4] = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h3e80_0000};
    foreach (v[i]) begin
      drive_one(v[i]);
      @(posedge clk); #1;
      model_step(v[i]);
      total++;
      if (obs !== exp_vec(1)) begin bad++; $display("FAIL sat_hi: got %h want %h", obs, exp_vec(1)); end
    end
    total++;
    if (y_out !== 32'h3e80_0000) begin bad++; $display("FAIL sat_hi_release: got %h want 3e800000", y_out); end
  endtask

  task automatic test_sat_lo();
    logic [31:0] v [3] = '{32'hc040_0000, 32'hff80_0000, 32'h8000_0000};
    foreach (v[i]) begin
      drive_one(v[i]);
      @(posedge clk); #1;
      model_step(v[i]);
      total++;
      if (obs !== exp_vec(1)) begin bad++; $display("FAIL sat_lo: got %h want %h", obs, exp_vec(1)); end
    end
    total++;
    if (y_out !== 32'h8000_0000) begin bad++; $display("FAIL neg_zero: got %h want 80000000", y_out); end
  endtask

  task automatic test_nan();
    logic [31:0] v [3] = '{32'h3f00_0000, 32'h7fc0_0000, 32'h3e80_0000};
    foreach (v[i]) begin
      drive_one(v[i]);
      @(posedge clk); #1;
      model_step(v[i]);
      total++;
      if (obs !== exp_vec(1)) begin bad++; $display("FAIL nan: got %h want %h", obs, exp_vec(1)); end
      @(posedge clk); #1;
      total++;
      if (obs !== exp_vec(0)) begin bad++; $display("FAIL nan_hold: got %h want %h", obs, exp_vec(0)); end
    end
  endtask

  // Scenario 0: async rst mid-flight; 1: rst_user mid-flight; 2: rst_user with sta.
  task automatic test_flush();
    for (int sc = 0; sc < 3; sc++) begin
      drive_one(32'h3f00_0000);
      @(posedge clk); #1;
      model_step(32'h3f00_0000);
      if (sc == 2) begin
        sta = 1; y_in = 32'h4000_0000; rst_user = 1;
        @(posedge clk); #1 sta = 0; rst_user = 0;
      end else begin
        drive_one(32'h4000_0000);
        if (sc == 0) begin
          rst = 0; #1;
        end else begin
          rst_user = 1;
          @(posedge clk); #1 rst_user = 0;
        end
      end
      model_reset();
      total++;
      if (obs !== exp_vec(0)) begin bad++; $display("FAIL flush%0d: got %h want %h", sc, obs, exp_vec(0)); end
      if (sc == 0) begin @(posedge clk); #1 rst = 1; end
      for (int k = 0; k < 2; k++) begin
        @(posedge clk); #1;
        total++;
        if (obs !== exp_vec(0)) begin bad++; $display("FAIL flush%0d_after: got %h want %h", sc, obs, exp_vec(0)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [9] = '{32'h3f00_0000, 32'h4000_0000, 32'hc040_0000, 32'h3e80_0000,
                           32'h4000_0000, 32'h4000_0000, 32'hc040_0000, 32'h4000_0000,
                           32'h4000_0000};
    for (int k = 0; k <= 9; k++) begin
      sta = (k < 9); y_in = (k < 9) ? v[k] : 32'h0;
      @(posedge clk); #1;
      if (k >= 1) model_step(v[k-1]);
      total++;
      if (obs !== exp_vec(k >= 1)) begin bad++; $display("FAIL b2b%0d: got %h want %h", k, obs, exp_vec(k >= 1)); end
    end
    sta = 0;
    @(posedge clk); #1;
    total++;
    if (obs !== exp_vec(0)) begin bad++; $display("FAIL b2b_idle: got %h want %h", obs, exp_vec(0)); end
    total++;
    if (sat_cnt2 !== 2'd3) begin bad++; $display("FAIL cnt_clamp: got %0d want 3", sat_cnt2); end
  endtask

  task automatic test_random();
    logic        s_d = 0;
    logic [31:0] y_d = '0;
    logic [31:0] m;
    logic [31:0] y;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 6))
        0: y = $urandom;
        1: begin m = 32'h3f80_0000 + $urandom_range(0, 4) - 2; y = {1'($urandom), m[30:0]}; end
        2: y = {1'($urandom), 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
        3: y = {1'($urandom), 8'hFF, 23'h0};
        4: y = {1'($urandom), 31'h0};
        default: y = {1'($urandom), 8'($urandom_range(100, 127)), 23'($urandom)};
      endcase
      sta = ($urandom_range(0, 3) != 0); y_in = y;
      @(posedge clk); #1;
      if (s_d) model_step(y_d);
      total++;
      if (obs !== exp_vec(s_d)) begin bad++; $display("FAIL rand%0d: got %h want %h", k, obs, exp_vec(s_d)); end
      s_d = sta; y_d = y;
    end
    sta = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_pass();
    test_sat_hi();
    test_sat_lo();
    test_nan();
    test_flush();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
